// File: rtl/pwm.sv
`default_nettype none
// ============================================================================
// Module : pwm
// Brief  : Multi-channel bus-mapped PWM with double-buffered period and duty
// Rev    : 1.0 - initial release
// ============================================================================
module pwm #(
  parameter int CHANNELS = 4,
  parameter int WIDTH    = 16
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [31:0]         address_in,
  input  logic                sel_in,
  input  logic                read_in,
  output logic [31:0]         read_value_out,
  input  logic [3:0]          write_mask_in,
  input  logic [31:0]         write_value_in,
  output logic                ready_out,
  output logic [CHANNELS-1:0] pwm_out
);

  localparam logic [2:0] c_OFF_CTRL   = 3'd0;
  localparam logic [2:0] c_OFF_PERIOD = 3'd1;
  localparam logic [2:0] c_OFF_COUNT  = 3'd2;
  localparam logic [2:0] c_OFF_STATUS = 3'd3;

  logic                r_ready_q;
  logic                r_en;
  logic                r_inv;
  logic                r_wrap;
  logic [WIDTH-1:0]    r_period_pend;
  logic [WIDTH-1:0]    r_period_act;
  logic [WIDTH-1:0]    r_count;
  logic [WIDTH-1:0]    r_duty_pend [CHANNELS];
  logic [WIDTH-1:0]    r_duty_act  [CHANNELS];
  logic [CHANNELS-1:0] r_pwm;

  logic                w_access;
  logic                w_write;
  logic [2:0]          w_off;
  logic                w_wrap_hit;
  logic                w_load;
  logic                w_status_clr;
  logic [31:0]         w_rdata;
  logic                w_unused;

  // Byte-lane merge of the bus write into an existing WIDTH-bit register.
  function automatic logic [WIDTH-1:0] lane_merge(input logic [WIDTH-1:0] old,
                                                  input logic [3:0]       mask,
                                                  input logic [31:0]      value);
    logic [31:0] v;
    v = 32'(old);
    for (int b = 0; b < 4; b++) begin
      if (mask[b]) v[8*b +: 8] = value[8*b +: 8];
    end
    return v[WIDTH-1:0];
  endfunction

  assign w_access     = r_ready_q & sel_in;
  assign w_write      = w_access & (|write_mask_in);
  assign w_off        = address_in[4:2];
  assign w_wrap_hit   = r_en & (r_count == r_period_act);
  assign w_load       = ~r_en | w_wrap_hit;
  assign w_status_clr = w_write & (w_off == c_OFF_STATUS) & write_mask_in[0] & write_value_in[0];
  assign ready_out    = w_access;
  assign pwm_out      = r_pwm;
  assign w_unused     = &{1'b0, address_in[31:5], address_in[1:0]};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_ready_q <= 1'b0;
    end else begin
      r_ready_q <= sel_in & ~r_ready_q;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_en          <= 1'b0;
      r_inv         <= 1'b0;
      r_wrap        <= 1'b0;
      r_period_pend <= '0;
      r_period_act  <= '0;
      r_count       <= '0;
    end else begin
      if (w_write && (w_off == c_OFF_CTRL) && write_mask_in[0]) begin
        r_en  <= write_value_in[0];
        r_inv <= write_value_in[1];
      end
      if (w_write && (w_off == c_OFF_PERIOD)) begin
        r_period_pend <= lane_merge(r_period_pend, write_mask_in, write_value_in);
      end
      if (w_load) begin
        r_period_act <= r_period_pend;
      end
      if (!r_en || w_wrap_hit) begin
        r_count <= '0;
      end else begin
        r_count <= r_count + WIDTH'(1);
      end
      // A wrap in the same cycle as a software clear must stay visible.
      if (w_wrap_hit) begin
        r_wrap <= 1'b1;
      end else if (w_status_clr) begin
        r_wrap <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_pwm <= '0;
      for (int n = 0; n < CHANNELS; n++) begin
        r_duty_pend[n] <= '0;
        r_duty_act[n]  <= '0;
      end
    end else begin
      for (int n = 0; n < CHANNELS; n++) begin
        if (w_write && (w_off == 3'(4 + n))) begin
          r_duty_pend[n] <= lane_merge(r_duty_pend[n], write_mask_in, write_value_in);
        end
        if (w_load) begin
          r_duty_act[n] <= r_duty_pend[n];
        end
        r_pwm[n] <= r_en & ((r_count < r_duty_act[n]) ^ r_inv);
      end
    end
  end

  always_comb begin
    w_rdata = '0;
    case (w_off)
      c_OFF_CTRL:   w_rdata = {30'd0, r_inv, r_en};
      c_OFF_PERIOD: w_rdata = 32'(r_period_pend);
      c_OFF_COUNT:  w_rdata = 32'(r_count);
      c_OFF_STATUS: w_rdata = {31'd0, r_wrap};
      default: begin
        for (int n = 0; n < CHANNELS; n++) begin
          if (w_off == 3'(4 + n)) w_rdata = 32'(r_duty_pend[n]);
        end
      end
    endcase
  end

  // Response bus is OR-ed with other peripherals, so idle data must be zero.
  assign read_value_out = (w_access & read_in) ? w_rdata : 32'd0;

endmodule
`default_nettype wire
